// File: rtl/int_seq_ctrl.sv
// Interrupt entry / RTI return sequencer sitting beside EX: drains, pushes PC (and CCR), vectors; RTI pops in reverse.
// Optional CCR save/restore is built when INT_SEQ_FLAGS_PUSH_EN is defined.
module int_seq_ctrl #(
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0020,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        INT_in,
  input  logic        is_RTI_in,
  input  logic        do_jmp_in,
  input  logic [31:0] ret_PC_in,
  input  logic [3:0]  flags_in,
  input  logic        mem_ack_in,
  input  logic [15:0] mem_data_in,
  output logic        stall_out,
  output logic        flush_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [15:0] mem_data_out,
  output logic [1:0]  SP_op_out,
  output logic        PC_load_out,
  output logic [31:0] PC_load_val_out,
  output logic        flags_load_out,
  output logic [3:0]  flags_val_out,
  output logic        busy_out
);

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_PCH,
    PUSH_PCL,
`ifdef INT_SEQ_FLAGS_PUSH_EN
    PUSH_FLG,
    POP_FLG,
`endif
    VEC,
    POP_PCL,
    POP_PCH,
    RESUME
  } state_t;

`ifdef INT_SEQ_FLAGS_PUSH_EN
  localparam state_t POP_FIRST = POP_FLG;
  localparam state_t AFTER_PCL = PUSH_FLG;
`else
  localparam state_t POP_FIRST = POP_PCL;
  localparam state_t AFTER_PCL = VEC;
`endif

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t      state, state_n;
  logic        pending;
  logic        enter_drain;
  logic        first_q;
  logic [3:0]  drain_cnt;
  logic [31:0] ret_pc;
  logic [15:0] pop_pch;
  logic [15:0] pop_pcl;
`ifdef INT_SEQ_FLAGS_PUSH_EN
  logic [3:0]  flags_q;
  logic [3:0]  pop_flg;
`else
  logic        unused_flags;
  assign unused_flags = ^flags_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      first_q   <= 1'b0;
      drain_cnt <= '0;
      ret_pc    <= '0;
      pop_pch   <= '0;
      pop_pcl   <= '0;
`ifdef INT_SEQ_FLAGS_PUSH_EN
      flags_q   <= '0;
      pop_flg   <= '0;
`endif
    end else begin
      state     <= state_n;
      first_q   <= (state_n != state);
      // a request arriving in the very cycle DRAIN is entered is kept, not lost
      pending   <= INT_in | (pending & ~enter_drain);
      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : '0;
      if (enter_drain) begin
        ret_pc <= ret_PC_in;
`ifdef INT_SEQ_FLAGS_PUSH_EN
        flags_q <= flags_in;
`endif
      end
      if (mem_ack_in) begin
        case (state)
`ifdef INT_SEQ_FLAGS_PUSH_EN
          POP_FLG: pop_flg <= mem_data_in[3:0];
`endif
          POP_PCL: pop_pcl <= mem_data_in;
          POP_PCH: pop_pch <= mem_data_in;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_n     = state;
    enter_drain = 1'b0;
    case (state)
      IDLE: begin
        if (is_RTI_in) begin
          state_n = POP_FIRST;
        end else if (pending && !do_jmp_in) begin
          state_n     = DRAIN;
          enter_drain = 1'b1;
        end
      end
      DRAIN:    if (drain_cnt == DRAIN_LAST) state_n = PUSH_PCH;
      PUSH_PCH: if (mem_ack_in) state_n = PUSH_PCL;
      PUSH_PCL: if (mem_ack_in) state_n = AFTER_PCL;
`ifdef INT_SEQ_FLAGS_PUSH_EN
      PUSH_FLG: if (mem_ack_in) state_n = VEC;
      POP_FLG:  if (mem_ack_in) state_n = POP_PCL;
`endif
      VEC:      state_n = IDLE;
      POP_PCL:  if (mem_ack_in) state_n = POP_PCH;
      POP_PCH:  if (mem_ack_in) state_n = RESUME;
      RESUME:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    stall_out       = (state != IDLE);
    busy_out        = (state != IDLE);
    flush_out       = 1'b0;
    mem_read_out    = 1'b0;
    mem_write_out   = 1'b0;
    mem_data_out    = '0;
    SP_op_out       = 2'b00;
    PC_load_out     = 1'b0;
    PC_load_val_out = '0;
    flags_load_out  = 1'b0;
    flags_val_out   = '0;
    case (state)
      DRAIN: flush_out = first_q;
      PUSH_PCH: begin
        mem_write_out = 1'b1;
        mem_data_out  = ret_pc[31:16];
        SP_op_out     = mem_ack_in ? 2'b01 : 2'b00;
      end
      PUSH_PCL: begin
        mem_write_out = 1'b1;
        mem_data_out  = ret_pc[15:0];
        SP_op_out     = mem_ack_in ? 2'b01 : 2'b00;
      end
`ifdef INT_SEQ_FLAGS_PUSH_EN
      PUSH_FLG: begin
        mem_write_out = 1'b1;
        mem_data_out  = {12'b0, flags_q};
        SP_op_out     = mem_ack_in ? 2'b01 : 2'b00;
      end
      POP_FLG: begin
        mem_read_out = 1'b1;
        flush_out    = first_q;
        SP_op_out    = mem_ack_in ? 2'b10 : 2'b00;
      end
`endif
      VEC: begin
        PC_load_out     = 1'b1;
        PC_load_val_out = INT_VECTOR;
      end
      POP_PCL: begin
        mem_read_out = 1'b1;
        flush_out    = first_q && (POP_FIRST == POP_PCL);
        SP_op_out    = mem_ack_in ? 2'b10 : 2'b00;
      end
      POP_PCH: begin
        mem_read_out = 1'b1;
        SP_op_out    = mem_ack_in ? 2'b10 : 2'b00;
      end
      RESUME: begin
        PC_load_out     = 1'b1;
        PC_load_val_out = {pop_pch, pop_pcl};
`ifdef INT_SEQ_FLAGS_PUSH_EN
        flags_load_out  = 1'b1;
        flags_val_out   = pop_flg;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_seq_ctrl.sv
// Self-checking bench for int_seq_ctrl: randomized interrupt/RTI traffic against a cycle-count model.
`timescale 1ns/1ps
module tb_int_seq_ctrl;
  localparam logic [31:0] VECTOR = 32'h0000_0020;
  localparam int DRAIN = 3;
`ifdef INT_SEQ_FLAGS_PUSH_EN
  localparam int NFLG = 1;
`else
  localparam int NFLG = 0;
`endif
  localparam int NACC = 2 + NFLG;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic INT_in = 1'b0, is_RTI_in = 1'b0, do_jmp_in = 1'b0;
  logic [31:0] ret_PC_in = '0;
  logic [3:0]  flags_in = '0;
  logic        mem_ack_in = 1'b0;
  logic [15:0] mem_data_in = '0;
  logic stall_out, flush_out, mem_read_out, mem_write_out, PC_load_out, flags_load_out, busy_out;
  logic [15:0] mem_data_out;
  logic [1:0]  SP_op_out;
  logic [31:0] PC_load_val_out;
  logic [3:0]  flags_val_out;
  logic [60:0] all_out;

  int compared = 0, mismatched = 0;
  int cyc = 0;

  int_seq_ctrl #(.INT_VECTOR(VECTOR), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .INT_in(INT_in), .is_RTI_in(is_RTI_in), .do_jmp_in(do_jmp_in),
    .ret_PC_in(ret_PC_in), .flags_in(flags_in), .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in),
    .stall_out(stall_out), .flush_out(flush_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .mem_data_out(mem_data_out), .SP_op_out(SP_op_out),
    .PC_load_out(PC_load_out), .PC_load_val_out(PC_load_val_out), .flags_load_out(flags_load_out),
    .flags_val_out(flags_val_out), .busy_out(busy_out));

  assign all_out = {busy_out, stall_out, flush_out, mem_read_out, mem_write_out, mem_data_out,
                    SP_op_out, PC_load_out, PC_load_val_out, flags_load_out, flags_val_out};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stack memory: per-access wait counts from wait_q, pop data from pop_q.
  logic [15:0] pop_q[$];
  int          wait_q[$];
  bit          in_acc = 0;
  int          rem = 0;
  always @(negedge clk) begin
    if (reset || !(mem_read_out || mem_write_out)) begin
      mem_ack_in = 1'b0;
      in_acc = 0;
    end else begin
      if (!in_acc) begin
        in_acc = 1;
        if (wait_q.size() > 0) rem = wait_q.pop_front();
        else rem = 0;
      end
      if (rem == 0) begin
        mem_ack_in = 1'b1;
        in_acc = 0;
        if (mem_read_out) begin
          if (pop_q.size() > 0) mem_data_in = pop_q.pop_front();
          else mem_data_in = 16'hDEAD;
        end
      end else begin
        rem--;
        mem_ack_in = 1'b0;
      end
    end
  end

  typedef struct { int c; logic [31:0] pc; logic fl; logic [3:0] flags; } load_t;
  load_t       loads[$];
  logic [15:0] wr_log[$];
  int          flush_log[$];
  logic [15:0] last_wdata = '0;
  bit          was_wait = 0;
  logic [1:0]  exp_sp;

  // Protocol invariants, checked every cycle away from the clock edge.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      compared++;
      if (mem_read_out && mem_write_out) begin
        mismatched++;
        $display("FAIL rw_exclusive: rd=%b wr=%b required not both high (cyc %0d)", mem_read_out, mem_write_out, cyc);
      end
      exp_sp = (mem_write_out && mem_ack_in) ? 2'b01 : (mem_read_out && mem_ack_in) ? 2'b10 : 2'b00;
      compared++;
      if (SP_op_out !== exp_sp) begin
        mismatched++;
        $display("FAIL sp_op: got %b required %b (cyc %0d)", SP_op_out, exp_sp, cyc);
      end
      if (mem_write_out && was_wait) begin
        compared++;
        if (mem_data_out !== last_wdata) begin
          mismatched++;
          $display("FAIL wdata_stable: got %h required %h (cyc %0d)", mem_data_out, last_wdata, cyc);
        end
      end
      was_wait = mem_write_out && !mem_ack_in;
      last_wdata = mem_data_out;
      if (mem_write_out && mem_ack_in) wr_log.push_back(mem_data_out);
      if (flush_out) flush_log.push_back(cyc);
      if (PC_load_out) loads.push_back('{cyc, PC_load_val_out, flags_load_out, flags_val_out});
    end else begin
      was_wait = 0;
    end
  end

  task automatic clear_logs();
    wr_log.delete(); loads.delete(); flush_log.delete(); wait_q.delete(); pop_q.delete();
  endtask

  task automatic wait_loads(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #3;
      if (loads.size() >= n) begin ok = 1; break; end
    end
  endtask

  // Model: entry vectors 1 (pending) + drain + pushes + 1 cycles after the pulse, plus jump deferral and waits.
  function automatic int int_load_at(int t0, int defer, int waits);
    return t0 + 1 + defer + DRAIN + NACC + 1 + waits;
  endfunction
  // Model: RTI spans 1 + pops + 1 cycles counting its own cycle, plus waits.
  function automatic int rti_load_at(int t0, int waits);
    return t0 + 1 + NACC + 1 - 1 + waits;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (all_out !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    compared++;
    if (all_out !== '0) begin
      mismatched++;
      $display("FAIL idle_after_reset: got %h required 0", all_out);
    end
  endtask

  task automatic test_int_entry(input int extra_wait, input string tag);
    int t0, waits; bit ok; logic [15:0] exp_w[$];
    clear_logs();
    wait_q.push_back(0); wait_q.push_back(extra_wait);
    waits = extra_wait;
    ret_PC_in = 32'h0001_2345; flags_in = 4'b1010;
    exp_w = '{16'h0001, 16'h2345};
    if (NFLG == 1) exp_w.push_back(16'h000A);
    t0 = cyc; INT_in = 1'b1;
    @(negedge clk); INT_in = 1'b0;
    wait_loads(1, 60, ok);
    compared++;
    if (!ok || loads[0].c != int_load_at(t0, 0, waits) || loads[0].pc !== VECTOR || loads[0].fl !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_vector: ok=%0d cyc=%0d pc=%h fl=%b required cyc=%0d pc=%h fl=0", tag, ok,
               ok ? loads[0].c : -1, ok ? loads[0].pc : 32'hx, ok ? loads[0].fl : 1'bx, int_load_at(t0, 0, waits), VECTOR);
    end
    compared++;
    if (wr_log.size() != exp_w.size()) begin
      mismatched++;
      $display("FAIL %s_wr_count: got %0d required %0d", tag, wr_log.size(), exp_w.size());
    end else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        compared++;
        if (wr_log[i] !== exp_w[i]) begin
          mismatched++;
          $display("FAIL %s_wr%0d: got %h required %h", tag, i, wr_log[i], exp_w[i]);
        end
      end
    end
    compared++;
    if (flush_log.size() != 1 || flush_log[0] != t0 + 2) begin
      mismatched++;
      $display("FAIL %s_flush: got %0d flushes first=%0d required 1 at %0d", tag, flush_log.size(),
               flush_log.size() > 0 ? flush_log[0] : -1, t0 + 2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rti();
    int t0; bit ok;
    clear_logs();
    if (NFLG == 1) pop_q.push_back(16'h0005);
    pop_q.push_back(16'hBEEF); pop_q.push_back(16'h0001);
    t0 = cyc; is_RTI_in = 1'b1;
    @(negedge clk); is_RTI_in = 1'b0;
    wait_loads(1, 40, ok);
    compared++;
    if (!ok || loads[0].c != rti_load_at(t0, 0) || loads[0].pc !== 32'h0001_BEEF) begin
      mismatched++;
      $display("FAIL rti_pc: ok=%0d cyc=%0d pc=%h required cyc=%0d pc=0001beef", ok,
               ok ? loads[0].c : -1, ok ? loads[0].pc : 32'hx, rti_load_at(t0, 0));
    end
    compared++;
    if (!ok || loads[0].fl !== 1'(NFLG) || loads[0].flags !== (NFLG == 1 ? 4'b0101 : 4'b0000)) begin
      mismatched++;
      $display("FAIL rti_flags: fl=%b flags=%b required fl=%0d flags=%b", ok ? loads[0].fl : 1'bx,
               ok ? loads[0].flags : 4'bx, NFLG, (NFLG == 1 ? 4'b0101 : 4'b0000));
    end
    compared++;
    if (wr_log.size() != 0 || flush_log.size() != 1 || flush_log[0] != t0 + 1) begin
      mismatched++;
      $display("FAIL rti_side: writes=%0d flushes=%0d required 0 writes, 1 flush at %0d", wr_log.size(), flush_log.size(), t0 + 1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ordering();
    int t0; bit ok;
    clear_logs();
    if (NFLG == 1) pop_q.push_back(16'h000C);
    pop_q.push_back(16'h1234); pop_q.push_back(16'h0042);
    ret_PC_in = 32'hCAFE_0100; flags_in = 4'b0011;
    t0 = cyc; INT_in = 1'b1; is_RTI_in = 1'b1;
    @(negedge clk); INT_in = 1'b0; is_RTI_in = 1'b0;
    @(negedge clk); INT_in = 1'b1;
    @(negedge clk); INT_in = 1'b0;
    wait_loads(2, 80, ok);
    repeat (30) @(negedge clk);
    #3;
    compared++;
    if (loads.size() != 2) begin
      mismatched++;
      $display("FAIL order_count: got %0d loads required 2", loads.size());
    end else begin
      compared++;
      if (loads[0].pc !== 32'h0042_1234 || loads[0].c != rti_load_at(t0, 0)) begin
        mismatched++;
        $display("FAIL order_rti_first: pc=%h cyc=%0d required pc=00421234 cyc=%0d", loads[0].pc, loads[0].c, rti_load_at(t0, 0));
      end
      compared++;
      if (loads[1].pc !== VECTOR || loads[1].c != int_load_at(rti_load_at(t0, 0), 0, 0)) begin
        mismatched++;
        $display("FAIL order_int_second: pc=%h cyc=%0d required pc=%h cyc=%0d", loads[1].pc, loads[1].c,
                 VECTOR, int_load_at(rti_load_at(t0, 0), 0, 0));
      end
    end
    compared++;
    if (wr_log.size() != NACC || (wr_log.size() > 0 && wr_log[0] !== 16'hCAFE)) begin
      mismatched++;
      $display("FAIL order_writes: got %0d writes first=%h required %0d first=cafe", wr_log.size(),
               wr_log.size() > 0 ? wr_log[0] : 16'hx, NACC);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    clear_logs();
    wait_q.push_back(0); wait_q.push_back(6);
    ret_PC_in = 32'h7777_8888;
    INT_in = 1'b1;
    @(negedge clk); INT_in = 1'b0;
    hit = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #3;
      if (mem_write_out && wr_log.size() == 1) begin hit = 1; break; end
    end
    reset = 1'b1;
    #1;
    compared++;
    if (!hit || all_out !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: reached_pcl=%0d got %h required 0", hit, all_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #3;
    compared++;
    if (wr_log.size() != 1 || loads.size() != 0 || busy_out !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_after: writes=%0d loads=%0d busy=%b required 1/0/0", wr_log.size(), loads.size(), busy_out);
    end
  endtask

  task automatic test_random(input int iters);
    int t0, waits, jmp; bit ok; bit is_rti;
    logic [31:0] pcs[4]; logic [3:0] fls[4];
    logic [15:0] pd[3]; logic [15:0] exp_w[$]; logic [31:0] exp_pc;
    for (int it = 0; it < iters; it++) begin
      clear_logs();
      waits = 0;
      for (int k = 0; k < NACC; k++) begin
        int w = $urandom_range(0, 2);
        wait_q.push_back(w); waits += w;
      end
      is_rti = bit'($urandom_range(0, 1));
      if (is_rti) begin
        for (int k = 0; k < 3; k++) pd[k] = 16'($urandom);
        if (NFLG == 1) pop_q.push_back(pd[0]);
        pop_q.push_back(pd[1]); pop_q.push_back(pd[2]);
        exp_pc = {pd[2], pd[1]};
        t0 = cyc; is_RTI_in = 1'b1;
        @(negedge clk); is_RTI_in = 1'b0;
        wait_loads(1, 40, ok);
        compared++;
        if (!ok || loads[0].c != rti_load_at(t0, waits) || loads[0].pc !== exp_pc ||
            loads[0].fl !== 1'(NFLG) || loads[0].flags !== (NFLG == 1 ? pd[0][3:0] : 4'b0000)) begin
          mismatched++;
          $display("FAIL rand_rti%0d: ok=%0d cyc=%0d pc=%h flags=%b required cyc=%0d pc=%h flags=%b", it, ok,
                   ok ? loads[0].c : -1, ok ? loads[0].pc : 32'hx, ok ? loads[0].flags : 4'bx,
                   rti_load_at(t0, waits), exp_pc, (NFLG == 1 ? pd[0][3:0] : 4'b0000));
        end
      end else begin
        jmp = $urandom_range(0, 1);
        for (int k = 0; k < 4; k++) begin pcs[k] = $urandom; fls[k] = 4'($urandom); end
        exp_w = '{pcs[1 + jmp][31:16], pcs[1 + jmp][15:0]};
        if (NFLG == 1) exp_w.push_back({12'b0, fls[1 + jmp]});
        t0 = cyc; INT_in = 1'b1; ret_PC_in = pcs[0]; flags_in = fls[0];
        @(negedge clk); INT_in = 1'b0; do_jmp_in = (jmp == 1); ret_PC_in = pcs[1]; flags_in = fls[1];
        @(negedge clk); do_jmp_in = 1'b0; ret_PC_in = pcs[2]; flags_in = fls[2];
        @(negedge clk); ret_PC_in = pcs[3]; flags_in = fls[3];
        wait_loads(1, 60, ok);
        compared++;
        if (!ok || loads[0].c != int_load_at(t0, jmp, waits) || loads[0].pc !== VECTOR) begin
          mismatched++;
          $display("FAIL rand_int%0d: ok=%0d cyc=%0d pc=%h required cyc=%0d pc=%h (jmp=%0d)", it, ok,
                   ok ? loads[0].c : -1, ok ? loads[0].pc : 32'hx, int_load_at(t0, jmp, waits), VECTOR, jmp);
        end
        compared++;
        if (wr_log != exp_w) begin
          mismatched++;
          $display("FAIL rand_int%0d_writes: got %p required %p", it, wr_log, exp_w);
        end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_int_entry(0, "entry");
    test_rti();
    test_int_entry(3, "memwait");
    test_ordering();
    test_random(24);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
